dac_cfg_sequencer: RTL and testbench

//  Upstream command sequencer for the DAC SPI serializer (dac_spi). Steps through a

---
 rtl/dac_cfg_sequencer.sv | 130 +++++++++++++
 tb/tb_dac_cfg_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_cfg_sequencer.sv
// rtl/dac_cfg_sequencer.sv - steps a sync-read table of 72-bit DAC words into the dac_spi serializer
// Optional WAIT_END timeout with sticky cfg_err: define DAC_CFG_TIMEOUT_EN.
module dac_cfg_sequencer #(
  parameter int NUM_WORDS      = 8,
  parameter int ADDR_W         = 7,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic              clk_20mhz_in,
  input  logic              spi_rst_in,
  input  logic              cfg_start,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [71:0]       tbl_data,
  output logic              spi_start,
  output logic [71:0]       spi_data_in,
  input  logic              spi_end,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [ADDR_W-1:0] word_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_START, S_WAIT_END, S_GAP, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [7:0]        GAP_LAST = 8'(GAP_CYCLES);

  if (NUM_WORDS < 1 || NUM_WORDS > 128 || (1 << ADDR_W) < NUM_WORDS ||
      GAP_CYCLES < 0 || GAP_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dac_cfg_sequencer: illegal parameter set");
  end

  state_t     state;
  logic [7:0] gap_cnt;

`ifdef DAC_CFG_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk_20mhz_in or posedge spi_rst_in) begin
    if (spi_rst_in) begin
      state       <= S_IDLE;
      tbl_addr    <= '0;
      word_idx    <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      gap_cnt     <= '0;
`ifdef DAC_CFG_TIMEOUT_EN
      to_cnt      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      spi_start <= 1'b0;
      cfg_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            word_idx <= '0;
            tbl_addr <= '0;
            cfg_busy <= 1'b1;
            state    <= S_FETCH;
`ifdef DAC_CFG_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
          end
        end
        // Table has one clock of read latency; tbl_addr was set on the way in.
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          spi_data_in <= tbl_data;
          spi_start   <= 1'b1;
          state       <= S_START;
        end
        S_START: begin
          state <= S_WAIT_END;
`ifdef DAC_CFG_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        S_WAIT_END: begin
          if (spi_end) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
`ifdef DAC_CFG_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            err_q    <= 1'b1;
            cfg_busy <= 1'b0;
            state    <= S_ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        // Gap spans GAP_CYCLES+1 clocks so a zero gap still leaves after one clock.
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (word_idx == LAST_IDX) begin
              cfg_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              word_idx <= word_idx + 1'b1;
              tbl_addr <= word_idx + 1'b1;
              state    <= S_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_DONE: begin
          cfg_busy <= 1'b0;
          state    <= S_IDLE;
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_cfg_sequencer.sv
// tb/tb_dac_cfg_sequencer.sv - directed bench for dac_cfg_sequencer (NUM_WORDS=3, GAP_CYCLES=4)
// Timeout checks are compiled in only with DAC_CFG_TIMEOUT_EN.
module tb_dac_cfg_sequencer;

  localparam int NW      = 3;
  localparam int AW      = 7;
  localparam int GAP     = 4;
  localparam int SER_LAT = 75;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          stray_end = 1'b0;
  logic          ser_end = 1'b0;
  logic [AW-1:0] tbl_addr, word_idx;
  logic [71:0]   tbl_data = '0;
  logic [71:0]   spi_data_in;
  logic          spi_start, spi_end, cfg_busy, cfg_done, cfg_err;

  assign spi_end = ser_end | stray_end;

  always #25 clk = ~clk;

  dac_cfg_sequencer #(
    .NUM_WORDS(NW), .ADDR_W(AW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk_20mhz_in(clk),
    .spi_rst_in(rst),
    .cfg_start(cfg_start),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .spi_start(spi_start),
    .spi_data_in(spi_data_in),
    .spi_end(spi_end),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err),
    .word_idx(word_idx)
  );

  logic [71:0] table_mem [4];
  always @(posedge clk) tbl_data <= table_mem[tbl_addr[1:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_start, n_end, n_done, n_unstable, ser_cnt, t_done;
  int          t_start [8];
  int          t_end [8];
  logic [71:0] cap_data [8];
  logic [AW-1:0] cap_idx [8];
  logic [71:0] held;
  bit          in_xfer;
  bit          ser_on = 1'b1;

  // Monitor plus serializer model: spi_end comes SER_LAT clocks after spi_start.
  always @(negedge clk) begin
    if (spi_start) begin
      if (n_start < 8) begin
        t_start[n_start]  = cyc;
        cap_data[n_start] = spi_data_in;
        cap_idx[n_start]  = word_idx;
      end
      n_start++;
      held    = spi_data_in;
      in_xfer = 1'b1;
    end else if (in_xfer && spi_data_in !== held) begin
      n_unstable++;
    end
    if (cfg_done) begin
      t_done = cyc;
      n_done++;
    end
    ser_end = 1'b0;
    if (spi_start && ser_on) ser_cnt = SER_LAT;
    else if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) ser_end = 1'b1;
    end
    if (ser_end && in_xfer) begin
      if (n_end < 8) t_end[n_end] = cyc;
      n_end++;
      in_xfer = 1'b0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    n_start = 0; n_end = 0; n_done = 0; n_unstable = 0;
    ser_cnt = 0; in_xfer = 1'b0; t_done = 0;
  endtask

  task automatic wait_starts(input int n, input int limit, input string name);
    int k = 0;
    while (n_start < n && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    chki(name, int'(n_start >= n), 1);
  endtask

  task automatic wait_ends(input int n, input int limit, input string name);
    int k = 0;
    while (n_end < n && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    chki(name, int'(n_end >= n), 1);
  endtask

  typedef struct {
    logic [71:0]   data;
    logic [AW-1:0] idx;
    int            lead;
  } vec_t;
  vec_t vec [NW];

  int t0;

  function automatic logic [146:0] outs_now();
    return {tbl_addr, word_idx, spi_start, spi_data_in, cfg_busy, cfg_done, cfg_err, 64'h0};
  endfunction

  task automatic run_seq(input bit inject);
    int k;
    clr();
    if (inject) begin
      @(negedge clk); stray_end = 1'b1;
      @(negedge clk); stray_end = 1'b0;
      repeat (3) @(negedge clk);
      chki("idle_stray_no_start", n_start, 0);
    end
    @(negedge clk);
    cfg_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    chk("busy_after_start", cfg_busy, 1'b1);
    if (inject) begin
      wait_starts(2, 400, "wait_word1");
      repeat (5) @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      wait_ends(2, 400, "wait_end1");
      @(negedge clk); stray_end = 1'b1;
      @(negedge clk); stray_end = 1'b0;
    end
    k = 0;
    while (n_done == 0 && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    chki("done_seen", int'(n_done > 0), 1);
    @(negedge clk); #1;
    chk("busy_after_done", cfg_busy, 1'b0);
    repeat (30) @(negedge clk);
    #1;
    chki("start_count", n_start, NW);
    chki("done_count", n_done, 1);
    chki("data_unstable", n_unstable, 0);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("word%0d_data", i), cap_data[i], vec[i].data);
      chk($sformatf("word%0d_idx", i), cap_idx[i], vec[i].idx);
      if (i == 0) chki("start_latency", t_start[0] - t0, vec[0].lead);
      else        chki($sformatf("gap_before_word%0d", i), t_start[i] - t_end[i-1], vec[i].lead);
    end
    chki("end_to_done", t_done - t_end[NW-1], 6);
  endtask

  initial begin
    table_mem[0] = 72'hA1_0011_2233_4455_6677;
    table_mem[1] = 72'hB2_8899_AABB_CCDD_EEFF;
    table_mem[2] = 72'hC3_0F1E_2D3C_4B5A_6978;
    table_mem[3] = 72'hFF_FFFF_FFFF_FFFF_FFFF;
    // Start lead is 3 clocks; later words start GAP+4 clocks after the previous spi_end.
    vec[0] = '{data: 72'hA1_0011_2233_4455_6677, idx: 7'd0, lead: 3};
    vec[1] = '{data: 72'hB2_8899_AABB_CCDD_EEFF, idx: 7'd1, lead: 8};
    vec[2] = '{data: 72'hC3_0F1E_2D3C_4B5A_6978, idx: 7'd2, lead: 8};
    clr();

    #1;
    chk("reset_outputs", outs_now(), '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_seq(1'b0);
    run_seq(1'b1);

    clr();
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    wait_starts(2, 400, "wait_word1_rst");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", outs_now(), '0);
    @(negedge clk);
    rst = 1'b0;
    n_start = 0;
    repeat (80) @(negedge clk);
    #1;
    chki("no_start_after_reset", n_start, 0);
    chk("idle_after_reset", cfg_busy, 1'b0);

`ifdef DAC_CFG_TIMEOUT_EN
    begin
      int k;
      int te;
      clr();
      ser_on = 1'b0;
      @(negedge clk); cfg_start = 1'b1;
      @(negedge clk); cfg_start = 1'b0;
      wait_starts(1, 50, "wait_start_to");
      k = 0; te = -1;
      while (k < 400) begin
        @(negedge clk); #1;
        k++;
        if (cfg_err) begin
          te = cyc;
          break;
        end
      end
      chki("timeout_cycle", te - t_start[0], 201);
      chk("busy_after_err", cfg_busy, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      chk("err_sticky", cfg_err, 1'b1);
      chki("no_done_on_err", n_done, 0);
      cfg_start = 1'b1;
      @(negedge clk); cfg_start = 1'b0;
      #1;
      chk("err_cleared", cfg_err, 1'b0);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      ser_on = 1'b1;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
